int_to_float: RTL and testbench
===============================

INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 input_a  input  32  two's-complement signed integer operand.
REQ-005 input_a_stb  input  1  upstream asserts while input_a is valid.
REQ-006 input_a_ack  output  1  block ready to accept input_a.
REQ-007 output_z  output  32  IEEE-754 single-precision result.
REQ-008 output_z_stb  output  1  output_z is valid.
REQ-009 output_z_ack  input  1  downstream accepts output_z.

Function
REQ-010 The block SHALL use a state machine with states get_a, convert_0, normalise, round, pack, put_z, and process one operand at a time with no pipelining.
REQ-011 get_a: input_a_ack SHALL be driven 1; a transfer occurs on an edge where input_a_ack and input_a_stb are both 1; the block then captures input_a, drives input_a_ack to 0 and moves to convert_0.
REQ-012 convert_0: if the operand is 0, the result SHALL be 0x00000000 (+0) and the state SHALL move to put_z; otherwise the block latches sign = bit 31 and magnitude = |operand| as 32-bit unsigned, sets working exponent to 31, and moves to normalise.
REQ-013 Magnitude of 0x80000000 SHALL be 0x80000000 (unsigned); no overflow or saturation case exists.
REQ-014 normalise: while magnitude bit 31 is 0, shift magnitude left by 1 and decrement exponent by 1, one shift per cycle; when bit 31 is 1, move to round.
REQ-015 round: mantissa = magnitude[31:8], guard = [7], round bit = [6], sticky = OR of [5:0]; round to nearest, ties to even: increment mantissa when guard=1 and (round bit|sticky|mantissa[0])=1.
REQ-016 A mantissa increment from 0xFFFFFF SHALL produce mantissa 0x800000 and exponent+1.
REQ-017 pack: output word = {sign, exponent+127 (8 bits), mantissa[22:0]}; then move to put_z.
REQ-018 put_z: output_z_stb SHALL be driven 1 and output_z driven with the packed word; both SHALL hold stable until an edge where output_z_stb and output_z_ack are both 1, after which output_z_stb goes 0 and the state returns to get_a.
REQ-019 output_z_ack while output_z_stb=0, and input_a_stb while input_a_ack=0, SHALL be ignored.
REQ-020 Latency: for a nonzero operand with k leading zeros in its magnitude (0..31), output_z_stb SHALL first be 1 exactly k+5 edges after the accept edge; for operand 0, exactly 2 edges after.
REQ-021 input_a_ack and output_z_stb SHALL never both be 1 in the same cycle.
REQ-022 After the output handshake, input_a_ack SHALL be 1 again one edge later (get_a re-entry).

Reset
REQ-023 On any edge with rst=0, the state SHALL become get_a, input_a_ack 0 and output_z_stb 0, overriding all other updates, including mid-conversion and mid-handshake; an in-flight operand is discarded.
REQ-024 output_z is not reset; its value is don't-care while output_z_stb=0.
REQ-025 The first edge with rst=1 after reset SHALL drive input_a_ack to 1.

Verification
REQ-026 Operand 0x00000001 -> 0x3F800000 after 36 edges (k=31); operand 0xFFFFFFFF (-1) -> 0xBF800000.
REQ-027 Operand 0x00000000 -> 0x00000000 with output_z_stb high 2 edges after accept; operand 0x80000000 -> 0xCF000000 with output_z_stb high 5 edges after accept.
REQ-028 Rounding: 0x7FFFFFFF -> 0x4F000000 (mantissa carry, exponent bump); 0x01000001 -> 0x4B800000 (tie to even, down); 0x01000003 -> 0x4B800002 (tie to even, up); 0x01000005 -> 0x4B800002 (tie to even, down).
REQ-029 Back-pressure: hold output_z_ack=0 for 10 cycles after output_z_stb rises -> output_z and output_z_stb stable throughout; input_a_ack stays 0; after ack, a second operand of 0xFFFFFF85 (-123) -> 0xC2F60000.
REQ-030 Reset mid-operation: assert rst=0 for one edge during normalise of 0x00000001 -> output_z_stb never rises for that operand; input_a_ack 1 on the first edge after release; a new operand of 0x00000002 -> 0x40000000.

Source files
------------

// File: rtl/int_to_float_if.sv
// int_to_float_if
//   Groups the operand and result handshakes of int_to_float.
//   Operand side : input_a (32b signed), input_a_stb (valid), input_a_ack (ready)
//   Result side  : output_z (32b IEEE-754 single), output_z_stb (valid), output_z_ack (ready)
//   master : the side that supplies operands and consumes results
//   slave  : the converter itself
interface int_to_float_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack
    );
endinterface

// File: rtl/int_to_float.sv
// int_to_float
//   Converts a 32-bit two's-complement integer to an IEEE-754 single-precision
//   value, round to nearest / ties to even. One operand in flight at a time.
//   Ports:
//     clk  - clock, all state changes on the rising edge
//     rst  - synchronous active-low reset
//     bus  - int_to_float_if.slave (operand in, result out, stb/ack handshakes)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   GET_A     | ready for an operand (input_a_ack high once settled)
//   CONVERT_0 | zero check; split operand into sign and magnitude
//   NORMALISE | shift magnitude left one bit per cycle until bit 31 set
//   ROUND     | take top 24 bits, round to nearest even on the low 8 bits
//   PACK      | assemble sign / biased exponent / fraction
//   PUT_Z     | present result until output_z_ack
module int_to_float (
    input  logic          clk,
    input  logic          rst,
    int_to_float_if.slave bus
);

    typedef enum logic [2:0] {
        GET_A,
        CONVERT_0,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        stb_q, stb_d;
    logic [31:0] a_q, a_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [23:0] mant_q, mant_d;
    logic [31:0] z_q, z_d;

    logic [23:0] mant_trunc;
    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [7:0]  exp_biased;

    assign mant_trunc = mag_q[31:8];
    assign guard_bit  = mag_q[7];
    assign round_bit  = mag_q[6];
    assign sticky_bit = |mag_q[5:0];
    // Ties go to the even mantissa: only round up on an exact half if the LSB is odd.
    assign round_up   = guard_bit & (round_bit | sticky_bit | mant_trunc[0]);
    // Exponent never exceeds 32, so the biased value fits in 8 bits.
    assign exp_biased = exp_q + 8'd127;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        stb_d   = stb_q;
        a_d     = a_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        mant_d  = mant_q;
        z_d     = z_q;

        case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (ack_q && bus.input_a_stb) begin
                    a_d     = bus.input_a;
                    ack_d   = 1'b0;
                    state_d = CONVERT_0;
                end
            end
            CONVERT_0: begin
                if (a_q == 32'd0) begin
                    z_d     = 32'd0;
                    state_d = PUT_Z;
                end else begin
                    sign_d  = a_q[31];
                    // Unsigned negate: 0x80000000 maps onto itself, which is the correct magnitude.
                    mag_d   = a_q[31] ? (~a_q + 32'd1) : a_q;
                    exp_d   = 8'd31;
                    state_d = NORMALISE;
                end
            end
            NORMALISE: begin
                if (!mag_q[31]) begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                mant_d = mant_trunc;
                if (round_up) begin
                    if (mant_trunc == 24'hFF_FFFF) begin
                        mant_d = 24'h80_0000;
                        exp_d  = exp_q + 8'd1;
                    end else begin
                        mant_d = mant_trunc + 24'd1;
                    end
                end
                state_d = PACK;
            end
            PACK: begin
                z_d     = {sign_q, exp_biased, mant_q[22:0]};
                state_d = PUT_Z;
            end
            PUT_Z: begin
                stb_d = 1'b1;
                if (stb_q && bus.output_z_ack) begin
                    stb_d   = 1'b0;
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
                ack_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= GET_A;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
        end
    end

    // Datapath carries no reset; its contents only matter once the FSM has loaded them.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        mag_q  <= mag_d;
        exp_q  <= exp_d;
        sign_q <= sign_d;
        mant_q <= mant_d;
        z_q    <= z_d;
    end

    assign bus.input_a_ack  = ack_q;
    assign bus.output_z_stb = stb_q;
    assign bus.output_z     = z_q;

endmodule

// File: tb/tb_int_to_float.sv
module tb_int_to_float;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int_to_float_if bus ();

    int_to_float dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Send one operand, measure edges from accept to output_z_stb, check result,
    // optionally hold back output_z_ack for 'hold' cycles, then complete the handshake.
    task automatic convert(input logic [31:0] a, input logic [31:0] exp_z,
                           input int exp_lat, input int hold, input string tag);
        int          n;
        int          lat;
        logic        stable;
        logic [31:0] z_seen;
        @(negedge clk);
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        n = 0;
        while (bus.input_a_ack !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack_ready"}, {31'd0, bus.input_a_ack}, 32'd1);
        @(posedge clk);
        #1;
        bus.input_a_stb = 1'b0;
        bus.input_a     = 32'hDEAD_BEEF;
        lat = 0;
        while (bus.output_z_stb !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, bus.output_z, exp_z);
        chk({tag, "_ack_low_while_stb"}, {31'd0, bus.input_a_ack}, 32'd0);
        if (hold > 0) begin
            stable = 1'b1;
            z_seen = bus.output_z;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (bus.output_z !== z_seen || bus.output_z_stb !== 1'b1 || bus.input_a_ack !== 1'b0)
                    stable = 1'b0;
            end
            chk({tag, "_backpressure_stable"}, {31'd0, stable}, 32'd1);
            chk({tag, "_result_after_hold"}, bus.output_z, exp_z);
        end
        bus.output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.output_z_ack = 1'b0;
        chk({tag, "_stb_drop"}, {31'd0, bus.output_z_stb}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_ack_return"}, {31'd0, bus.input_a_ack}, 32'd1);
    endtask

    initial begin
        logic quiet;
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        bus.input_a      = 32'd0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b1;   // ack with no valid result must be ignored
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, bus.input_a_ack}, 32'd0);
        chk("reset_stb", {31'd0, bus.output_z_stb}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.output_z_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("release_ack", {31'd0, bus.input_a_ack}, 32'd1);
        chk("release_stb", {31'd0, bus.output_z_stb}, 32'd0);

        convert(32'h0000_0001, 32'h3F80_0000, 36, 0, "one");
        convert(32'hFFFF_FFFF, 32'hBF80_0000, 36, 0, "minus_one");
        convert(32'h0000_0000, 32'h0000_0000, 2,  0, "zero");
        convert(32'h8000_0000, 32'hCF00_0000, 5,  0, "int_min");
        convert(32'h7FFF_FFFF, 32'h4F00_0000, 6,  0, "int_max_carry");
        convert(32'h0100_0001, 32'h4B80_0000, 12, 0, "tie_even_down");
        convert(32'h0100_0003, 32'h4B80_0002, 12, 0, "tie_even_up");
        convert(32'h0100_0005, 32'h4B80_0002, 12, 0, "tie_even_down2");
        convert(32'h0000_007B, 32'h42F6_0000, 30, 10, "bp_first");
        convert(32'hFFFF_FF85, 32'hC2F6_0000, 30, 0, "minus_123");

        // Reset during normalise of operand 1
        @(negedge clk);
        bus.input_a     = 32'h0000_0001;
        bus.input_a_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.input_a_stb = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ack_low", {31'd0, bus.input_a_ack}, 32'd0);
        chk("midrst_stb_low", {31'd0, bus.output_z_stb}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ack_release", {31'd0, bus.input_a_ack}, 32'd1);
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.output_z_stb !== 1'b0) quiet = 1'b0;
        end
        chk("midrst_no_result", {31'd0, quiet}, 32'd1);
        convert(32'h0000_0002, 32'h4000_0000, 35, 0, "after_reset_two");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
